// File: rtl/muxn_pkg.sv
// muxn_pkg: shared constants and helpers for the muxn_pipe block.
// Holds the channel-slice helper and the legal NUM_IN range check.
package muxn_pkg;

    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 64;

    // Bit offset of channel idx inside the flattened data bus.
    function automatic int unsigned chan_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    // True when a channel count is inside the supported range.
    function automatic bit num_in_legal(input int n);
        return (n >= NUM_IN_MIN) && (n <= NUM_IN_MAX);
    endfunction

endpackage

// File: rtl/muxn_pipe_rr.sv
// muxn_rr_arb: round-robin grant generator for muxn_pipe.
// Searches in_valid from ptr upward with wrap-around; ptr advances past the
// granted channel only when a transfer actually happens.
module muxn_rr_arb
    import muxn_pkg::*;
#(
    parameter int NUM_IN    = 16,
    parameter int SEL_WIDTH = $clog2(NUM_IN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IN-1:0]    in_valid,
    input  logic                 xfer,
    output logic [SEL_WIDTH-1:0] g,
    output logic [SEL_WIDTH-1:0] ptr
);

    logic [SEL_WIDTH:0]   sum;
    logic [SEL_WIDTH-1:0] idx;
    logic                 found;

    // Pick the first valid channel at or after ptr, wrapping at NUM_IN-1.
    always_comb begin
        g     = ptr;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sum = {1'b0, ptr} + (SEL_WIDTH+1)'(k);
            if (sum >= (SEL_WIDTH+1)'(NUM_IN)) begin
                sum = sum - (SEL_WIDTH+1)'(NUM_IN);
            end
            idx = sum[SEL_WIDTH-1:0];
            if (!found && in_valid[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
    end

    // Pointer moves to the channel after the winner on each transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (g == SEL_WIDTH'(NUM_IN - 1)) ? '0 : g + 1'b1;
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// muxn_pipe: N-input mux with a registered valid/ready output stage.
// Build option: define MUXN_PIPE_RR_EN to replace sel with a round-robin
// arbiter (muxn_rr_arb); otherwise the grant comes straight from sel.
// Handshake: a word moves when valid && ready on the same rising edge; the
// output register accepts whenever it is empty or draining this cycle.
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 16,
    parameter int SEL_WIDTH  = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [SEL_WIDTH-1:0]         sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_WIDTH-1:0]         out_sel
);

    if (!num_in_legal(NUM_IN)) begin : g_bad_num_in
        $error("muxn_pipe: NUM_IN out of range 2..64");
    end

    logic                  accept;
    logic [SEL_WIDTH-1:0]  g;
    logic                  g_ok;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] g_data;

`ifdef MUXN_PIPE_RR_EN
    logic [SEL_WIDTH-1:0] unused_ptr;
    logic                 unused_sel;

    assign unused_sel = ^sel;
    assign g_ok       = 1'b1;

    muxn_rr_arb #(
        .NUM_IN    (NUM_IN),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .xfer     (xfer),
        .g        (g),
        .ptr      (unused_ptr)
    );
`else
    assign g    = sel;
    assign g_ok = (32'(sel) < 32'(NUM_IN));
`endif

    assign accept = !out_valid || out_ready;
    assign xfer   = g_ok && in_valid[g] && accept && !rst;
    assign g_data = in_data[chan_lo(32'(g), DATA_WIDTH) +: DATA_WIDTH];

    // Only the granted channel sees ready, and never during reset.
    always_comb begin
        in_ready = '0;
        if (g_ok && !rst) begin
            in_ready[g] = accept;
        end
    end

    // Output register: load on transfer, clear valid on a pure drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_sel   <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: self-checking bench for muxn_pipe (select mode by default,
// round-robin mode when MUXN_PIPE_RR_EN is defined).
`timescale 1ns/1ps
module tb_muxn_pipe;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    // {sel (8 bits), data}
    logic [DW+7:0] exp_q[$];
    logic [DW+7:0] e;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

`ifndef MUXN_PIPE_RR_EN
    // ---------------- select mode: NUM_IN=16 and NUM_IN=12 ----------------
    logic [16*DW-1:0] a_in_data;
    logic [15:0]      a_in_valid, a_in_ready;
    logic [3:0]       a_sel, a_out_sel;
    logic [DW-1:0]    a_out_data;
    logic             a_out_valid, a_out_ready;

    logic [12*DW-1:0] b_in_data;
    logic [11:0]      b_in_valid, b_in_ready;
    logic [3:0]       b_sel, b_out_sel;
    logic [DW-1:0]    b_out_data;
    logic             b_out_valid, b_out_ready;

    muxn_pipe #(.DATA_WIDTH(DW), .NUM_IN(16)) d16 (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sel(a_out_sel)
    );

    muxn_pipe #(.DATA_WIDTH(DW), .NUM_IN(12)) d12 (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sel(b_out_sel)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] valid;
        logic [15:0] exp_ready;
    } vec_t;
    vec_t tbl[8];

    logic m_valid = 1'b0;

    // Reference model of the 16-input output register; pushes accepted words.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
        end else if (!(m_valid && !a_out_ready) && a_in_valid[a_sel]) begin
            exp_q.push_back({4'h0, a_sel, a_in_data[a_sel*DW +: DW]});
            m_valid = 1'b1;
        end else if (a_out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Scoreboard: every consumed word must match the oldest accepted one.
    always @(negedge clk) begin
        if (!rst) begin
            check("sb_valid", a_out_valid, m_valid);
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got word %0h expected none", a_out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sel", a_out_sel, e[DW+7:DW]);
                    check("sb_data", a_out_data, e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] s;
        rst = 1'b1;
        a_in_valid = '1; a_sel = 4'd0; a_out_ready = 1'b0;
        b_in_valid = '1; b_sel = 4'd0; b_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) a_in_data[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
        for (int i = 0; i < 12; i++) b_in_data[i*DW +: DW] = 32'h1200_0000 | 32'(i);

        for (int i = 0; i < 8; i++) begin
            s = 4'($urandom_range(0, 15));
            if (i == 0) s = 4'd0;
            if (i == 1) s = 4'd15;
            tbl[i].sel       = s;
            tbl[i].valid     = 16'($urandom_range(0, 65535));
            if (i % 2 == 0) tbl[i].valid[s] = 1'b1;
            tbl[i].exp_ready = 16'd1 << s;
        end

        // reset: two cycles with all valids high
        repeat (2) begin
            @(negedge clk);
            check("rst_out_valid", a_out_valid, 0);
            check("rst_out_data", a_out_data, 0);
            check("rst_out_sel", a_out_sel, 0);
            check("rst_in_ready", a_in_ready, 0);
            check("rst_in_ready12", b_in_ready, 0);
        end

        // select path
        @(posedge clk); #1;
        rst = 1'b0;
        a_in_valid = 16'h0020; a_sel = 4'd5; a_out_ready = 1'b1;
        @(negedge clk);
        check("sel5_in_ready", a_in_ready, 16'h0020);

        // back-pressure with sel switched to 9
        @(posedge clk); #1;
        a_out_ready = 1'b0; a_sel = 4'd9; a_in_valid = 16'h0200;
        a_in_data[9*DW +: DW] = 32'h9999_0009;
        @(negedge clk);
        check("sel5_out_valid", a_out_valid, 1);
        check("sel5_out_data", a_out_data, 32'hA5A5_0005);
        check("sel5_out_sel", a_out_sel, 5);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", a_in_ready, 0);
            check("bp_out_data", a_out_data, 32'hA5A5_0005);
            check("bp_out_sel", a_out_sel, 5);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", a_in_ready, 16'h0200);
        @(posedge clk); #1;
        a_in_valid = '0;
        @(negedge clk);
        check("bp_ch9_sel", a_out_sel, 9);
        check("bp_ch9_data", a_out_data, 32'h9999_0009);

        // table of select/valid patterns at full throughput
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            a_sel = tbl[i].sel;
            a_in_valid = tbl[i].valid;
            for (int c = 0; c < 16; c++) a_in_data[c*DW +: DW] = $urandom;
            @(negedge clk);
            check("tbl_in_ready", a_in_ready, tbl[i].exp_ready);
        end

        // random traffic with random back-pressure
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            a_sel = 4'($urandom_range(0, 15));
            a_in_valid = 16'($urandom_range(0, 65535));
            a_out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 16; c++) a_in_data[c*DW +: DW] = $urandom;
        end
        @(posedge clk); #1;
        a_in_valid = '0; a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);

        // out-of-range select on the 12-input instance (holding channel 0)
        @(posedge clk); #1;
        b_sel = 4'd13;
        @(negedge clk);
        check("oor_hold_valid", b_out_valid, 1);
        check("oor_hold_data", b_out_data, 32'h1200_0000);
        check("oor_in_ready", b_in_ready, 0);
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        @(negedge clk);
        check("oor_drain_in_ready", b_in_ready, 0);
        @(negedge clk);
        check("oor_drained_valid", b_out_valid, 0);
        check("oor_idle_in_ready", b_in_ready, 0);
        @(posedge clk); #1;
        b_sel = 4'd11;
        @(negedge clk);
        check("top_ch_in_ready", b_in_ready, 12'h800);
        @(negedge clk);
        check("top_ch_out_sel", b_out_sel, 11);
        check("top_ch_out_data", b_out_data, 32'h1200_000B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

`else
    // ---------------- round-robin mode: NUM_IN=4 ----------------
    logic [4*DW-1:0] r_in_data;
    logic [3:0]      r_in_valid, r_in_ready;
    logic [1:0]      r_sel, r_out_sel;
    logic [DW-1:0]   r_out_data;
    logic            r_out_valid, r_out_ready;

    muxn_pipe #(.DATA_WIDTH(DW), .NUM_IN(4)) d4 (
        .clk(clk), .rst(rst), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_sel(r_out_sel)
    );

    typedef struct {
        logic [1:0] exp_sel;
    } rr_t;
    rr_t seq[6];

    initial begin
        logic [1:0] order[3];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3;
        for (int i = 0; i < 6; i++) seq[i].exp_sel = order[i % 3];

        rst = 1'b1;
        r_in_valid = '1; r_sel = 2'd2; r_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) r_in_data[i*DW +: DW] = 32'hC0DE_0000 | 32'(i);

        repeat (2) begin
            @(negedge clk);
            check("rst_out_valid", r_out_valid, 0);
            check("rst_out_data", r_out_data, 0);
            check("rst_out_sel", r_out_sel, 0);
            check("rst_in_ready", r_in_ready, 0);
        end

        @(posedge clk); #1;
        rst = 1'b0; r_in_valid = 4'b1011; r_out_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            exp_q.push_back({6'h0, seq[i].exp_sel, 32'hC0DE_0000 | 32'(seq[i].exp_sel)});
        @(negedge clk);
        check("rr_first_in_ready", r_in_ready, 4'b0001);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_out_valid", r_out_valid, 1);
            e = exp_q.pop_front();
            check("rr_out_sel", r_out_sel, e[DW+7:DW]);
            check("rr_out_data", r_out_data, e[DW-1:0]);
            if (i == 5) r_in_valid = 4'b0010;
        end

        // channel 1 wins, ptr moves to 2; then reset mid-stream
        @(posedge clk); #1;
        rst = 1'b1; r_in_valid = 4'b1111;
        @(negedge clk);
        check("pre_rst_out_valid", r_out_valid, 1);
        check("pre_rst_out_sel", r_out_sel, 1);
        check("rst_cycle_in_ready", r_in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; r_in_valid = 4'b1110;
        exp_q.push_back({6'h0, 2'd1, 32'hC0DE_0001});
        @(negedge clk);
        check("post_rst_out_valid", r_out_valid, 0);
        check("post_rst_in_ready", r_in_ready, 4'b0010);
        @(posedge clk); #1;
        r_in_valid = '0;
        @(negedge clk);
        check("post_rst_valid", r_out_valid, 1);
        e = exp_q.pop_front();
        check("post_rst_sel", r_out_sel, e[DW+7:DW]);
        check("post_rst_data", r_out_data, e[DW-1:0]);
        @(negedge clk);
        check("rr_drained", r_out_valid, 0);
        check("rr_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
`endif

endmodule
